// File: rtl/mandel_iter_core.sv
// Mandelbrot escape-time engine: iterates z = z^2 + c in signed Q3.13, one step per clock,
// and reports the iteration count at escape or at the cap through a start/done handshake.
module mandel_iter_core #(
  parameter int unsigned MAX_ITER = 127
) (
  input  logic        CLK_100MHz,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] c_re,
  input  logic [15:0] c_im,
  output logic        busy,
  output logic        done,
  output logic [7:0]  iter_count,
  output logic        escaped
);

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  localparam logic [7:0]         MaxIter  = 8'(MAX_ITER);
  localparam logic signed [23:0] SatMax   = 24'sd32767;
  localparam logic signed [23:0] SatMin   = -24'sd32768;
  localparam logic signed [23:0] EscLimit = 24'sd32768;

  state_e             r_state, w_state_d;
  logic signed [15:0] r_zr, r_zi, r_cre, r_cim;
  logic [7:0]         r_n;
  logic [7:0]         r_iter_count;
  logic               r_escaped;

  logic signed [31:0] w_zr_ext, w_zi_ext;
  logic signed [31:0] w_prod_rr, w_prod_ii, w_prod_ri;
  logic signed [23:0] w_pr, w_pi, w_px, w_mag, w_re_next, w_im_next;
  logic               w_escape, w_cap;

  function automatic logic signed [15:0] sat16(input logic signed [23:0] v);
    if (v > SatMax) return 16'sh7FFF;
    else if (v < SatMin) return 16'sh8000;
    else return v[15:0];
  endfunction

  // 32-bit products cannot overflow: |z|^2 <= 2^30.
  assign w_zr_ext  = {{16{r_zr[15]}}, r_zr};
  assign w_zi_ext  = {{16{r_zi[15]}}, r_zi};
  assign w_prod_rr = w_zr_ext * w_zr_ext;
  assign w_prod_ii = w_zi_ext * w_zi_ext;
  assign w_prod_ri = w_zr_ext * w_zi_ext;

  assign w_pr = {{5{w_prod_rr[31]}}, w_prod_rr[31:13]};
  assign w_pi = {{5{w_prod_ii[31]}}, w_prod_ii[31:13]};
  assign w_px = {{5{w_prod_ri[31]}}, w_prod_ri[31:13]};

  assign w_mag     = w_pr + w_pi;
  assign w_re_next = w_pr - w_pi + {{8{r_cre[15]}}, r_cre};
  assign w_im_next = (w_px <<< 1) + {{8{r_cim[15]}}, r_cim};

  assign w_escape = w_mag > EscLimit;
  assign w_cap    = r_n == MaxIter;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_d = StIter;
      StIter:  if (w_escape || w_cap) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_100MHz) begin
    if (reset) begin
      r_state      <= StIdle;
      r_zr         <= '0;
      r_zi         <= '0;
      r_cre        <= '0;
      r_cim        <= '0;
      r_n          <= '0;
      r_iter_count <= '0;
      r_escaped    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_cre <= c_re;
            r_cim <= c_im;
            r_zr  <= '0;
            r_zi  <= '0;
            r_n   <= '0;
          end
        end
        StIter: begin
          if (w_escape) begin
            r_iter_count <= r_n;
            r_escaped    <= 1'b1;
          end else if (w_cap) begin
            r_iter_count <= MaxIter;
            r_escaped    <= 1'b0;
          end else begin
            r_zr <= sat16(w_re_next);
            r_zi <= sat16(w_im_next);
            r_n  <= r_n + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = r_state != StIdle;
  assign done       = r_state == StDone;
  assign iter_count = r_iter_count;
  assign escaped    = r_escaped;

endmodule

// File: tb/tb_mandel_iter_core.sv
// Directed bench for mandel_iter_core: hand-computed orbits, handshake timing,
// back-to-back spacing and mid-computation reset.
module tb_mandel_iter_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] c_re, c_im;
  logic        busy, done, escaped;
  logic [7:0]  iter_count;

  int total = 0;
  int bad   = 0;

  mandel_iter_core #(.MAX_ITER(127)) dut (
    .CLK_100MHz (clk),
    .reset      (reset),
    .start      (start),
    .c_re       (c_re),
    .c_im       (c_im),
    .busy       (busy),
    .done       (done),
    .iter_count (iter_count),
    .escaped    (escaped)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; c_re = '0; c_im = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (iter_count !== 8'd0) begin bad++; $display("FAIL reset_iter got=%0d want=0", iter_count); end
    total++; if (escaped !== 1'b0) begin bad++; $display("FAIL reset_esc got=%b want=0", escaped); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  // Each row: c_re, c_im, expected count, expected escaped, toggle c inputs during ITER.
  task automatic test_points();
    logic [15:0] t_re [6] = '{16'h0000, 16'h4000, 16'hC000, 16'h2000, 16'h0000, 16'hE000};
    logic [15:0] t_im [6] = '{16'h0000, 16'h0000, 16'h0000, 16'h2000, 16'h5000, 16'h0000};
    int          t_n  [6] = '{127, 2, 127, 2, 1, 127};
    logic        t_esc[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        t_tog[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      int   edges;
      logic busy_low;
      @(negedge clk);
      c_re = t_re[i]; c_im = t_im[i]; start = 1'b1;
      @(posedge clk);
      edges = 0; busy_low = 1'b0;
      @(negedge clk);
      start = 1'b0;
      while (done !== 1'b1 && edges < 300) begin
        if (busy !== 1'b1) busy_low = 1'b1;
        if (t_tog[i]) begin
          c_re = edges[0] ? 16'h7FFF : 16'h8000;
          c_im = edges[0] ? 16'h8000 : 16'h7FFF;
        end
        @(posedge clk); edges++;
        @(negedge clk);
      end
      total++;
      if (edges + 1 != t_n[i] + 2) begin
        bad++; $display("FAIL pt%0d_latency got=%0d want=%0d", i, edges + 1, t_n[i] + 2);
      end
      total++;
      if (iter_count !== 8'(t_n[i])) begin
        bad++; $display("FAIL pt%0d_iter got=%0d want=%0d", i, iter_count, t_n[i]);
      end
      total++;
      if (escaped !== t_esc[i]) begin
        bad++; $display("FAIL pt%0d_esc got=%b want=%b", i, escaped, t_esc[i]);
      end
      total++;
      if (busy_low || busy !== 1'b1) begin
        bad++; $display("FAIL pt%0d_busy_hold got=low want=high", i);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL pt%0d_after got=done%b/busy%b want=0/0", i, done, busy);
      end
      total++;
      if (iter_count !== 8'(t_n[i])) begin
        bad++; $display("FAIL pt%0d_hold got=%0d want=%0d", i, iter_count, t_n[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int idx[4];
    int cnt = 0;
    @(negedge clk);
    c_re = 16'h4000; c_im = 16'h0000; start = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done === 1'b1 && cnt < 4) begin
        idx[cnt] = cyc; cnt++;
        total++;
        if (iter_count !== 8'd2) begin
          bad++; $display("FAIL b2b_iter got=%0d want=2", iter_count);
        end
      end
    end
    start = 1'b0;
    total++;
    if (cnt < 3) begin
      bad++; $display("FAIL b2b_count got=%0d want>=3", cnt);
    end else begin
      total++;
      if (idx[1] - idx[0] != 5) begin
        bad++; $display("FAIL b2b_gap0 got=%0d want=5", idx[1] - idx[0]);
      end
      total++;
      if (idx[2] - idx[1] != 5) begin
        bad++; $display("FAIL b2b_gap1 got=%0d want=5", idx[2] - idx[1]);
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_abort();
    int   edges;
    logic seen_done = 1'b0;
    @(negedge clk);
    c_re = 16'h0000; c_im = 16'h0000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
    total++;
    if (iter_count !== 8'd0) begin bad++; $display("FAIL abort_iter got=%0d want=0", iter_count); end
    total++; if (escaped !== 1'b0) begin bad++; $display("FAIL abort_esc got=%b want=0", escaped); end
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    total++;
    if (seen_done) begin bad++; $display("FAIL abort_quiet got=activity want=none"); end
    start = 1'b1;
    @(posedge clk);
    edges = 0;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && edges < 300) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    total++;
    if (edges + 1 != 129) begin bad++; $display("FAIL abort_relat got=%0d want=129", edges + 1); end
    total++;
    if (iter_count !== 8'd127) begin
      bad++; $display("FAIL abort_reiter got=%0d want=127", iter_count);
    end
    total++;
    if (escaped !== 1'b0) begin bad++; $display("FAIL abort_reesc got=%b want=0", escaped); end
  endtask

  initial begin
    test_reset();
    test_points();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
